// File: rtl/dcache_burst.sv
// Direct-mapped write-through data cache with word-by-word line refill.
// Optional DCACHE_WRITE_ALLOCATE_EN: a write miss refills the line before the memory write.
module dcache_burst #(
  parameter int CACHE_SIZE = 1024,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_request,
  input  logic        write_request,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strb,
  input  logic        invalidate,
  output logic        response,
  output logic [31:0] read_data,
  output logic        memory_read_request,
  output logic        memory_write_request,
  input  logic        memory_response,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_write_data,
  output logic [3:0]  memory_write_strb,
  input  logic [31:0] memory_read_data
);

  // state   | meaning
  // IDLE    | accept requests, serve read hits combinationally, apply invalidate
  // REFILL  | fetch line words from memory, offset 0 upward
  // WRITE   | write-through of the store word to memory
  // RESPOND | one-cycle completion pulse, then IDLE

  localparam int SETS  = CACHE_SIZE / (4 * LINE_WORDS);
  localparam int OFF_B = $clog2(LINE_WORDS);
  localparam int IDX_B = $clog2(SETS);
  localparam int WI_B  = OFF_B + IDX_B;
  localparam int TAG_B = 30 - WI_B;
  localparam int CNT_B = (OFF_B > 0) ? OFF_B : 1;

`ifdef DCACHE_WRITE_ALLOCATE_EN
  localparam bit ALLOC = 1'b1;
`else
  localparam bit ALLOC = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESPOND} state_t;
  state_t state, state_nxt;

  logic [31:0]      data_mem [SETS*LINE_WORDS];
  logic [TAG_B-1:0] tag_mem  [SETS];
  logic [SETS-1:0]  valid;
  logic [CNT_B-1:0] cnt;
  logic             inv_pend;

  logic [TAG_B-1:0] req_tag;
  logic [IDX_B-1:0] req_idx;
  logic [WI_B-1:0]  req_word;
  logic [29:0]      refill_word;
  logic [WI_B-1:0]  fill_word;
  logic             hit, last_beat, wr_hit_en, fill_en;
  logic             unused_addr_bits;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  assign unused_addr_bits = ^addr[1:0];
  assign req_tag     = addr[31:2+WI_B];
  assign req_idx     = addr[1+WI_B:2+OFF_B];
  assign req_word    = addr[1+WI_B:2];
  // flat word address: line base of the request plus the refill beat count
  assign refill_word = (addr[31:2] & ~30'(LINE_WORDS - 1)) | 30'(cnt);
  assign fill_word   = refill_word[WI_B-1:0];
  assign hit         = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign last_beat   = (cnt == CNT_B'(LINE_WORDS - 1));
  assign wr_hit_en   = rst_n && (state == IDLE) && !invalidate && write_request && hit;
  assign fill_en     = rst_n && (state == REFILL) && memory_response;

  always_comb begin
    state_nxt            = state;
    response             = 1'b0;
    read_data            = data_mem[req_word];
    memory_read_request  = 1'b0;
    memory_write_request = 1'b0;
    memory_addr          = '0;
    memory_write_data    = '0;
    memory_write_strb    = '0;
    case (state)
      IDLE: begin
        if (invalidate) begin
          state_nxt = IDLE;
        end else if (write_request) begin
          state_nxt = (hit || !ALLOC) ? WRITE : REFILL;
        end else if (read_request) begin
          if (hit) response = 1'b1;
          else     state_nxt = REFILL;
        end
      end
      REFILL: begin
        memory_read_request = 1'b1;
        memory_addr         = {refill_word, 2'b00};
        if (memory_response && last_beat)
          state_nxt = write_request ? WRITE : RESPOND;
      end
      WRITE: begin
        memory_write_request = 1'b1;
        memory_addr          = {addr[31:2], 2'b00};
        memory_write_data    = write_data;
        memory_write_strb    = write_strb;
        if (memory_response) state_nxt = RESPOND;
      end
      RESPOND: begin
        response  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      valid    <= '0;
      cnt      <= '0;
      inv_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && invalidate)
        valid <= '0;
      else if (state == RESPOND && (inv_pend || invalidate))
        valid <= '0;
      else if (fill_en && last_beat)
        valid[req_idx] <= 1'b1;
      if (state == RESPOND)
        inv_pend <= 1'b0;
      else if (state != IDLE && invalidate)
        inv_pend <= 1'b1;
      if (fill_en)
        cnt <= last_beat ? '0 : cnt + 1'b1;
    end
  end

  // a write-allocate refill merges the store into its word as that beat arrives
  always_ff @(posedge clk) begin
    if (wr_hit_en)
      data_mem[req_word] <= merge(data_mem[req_word], write_data, write_strb);
    if (fill_en)
      data_mem[fill_word] <= (write_request && fill_word == req_word) ?
                             merge(memory_read_data, write_data, write_strb) : memory_read_data;
    if (fill_en && last_beat)
      tag_mem[req_idx] <= req_tag;
  end

endmodule

// File: doc/dcache_burst.md
DCACHE_BURST -- requirements
Module: dcache_burst

Interface
REQ-001 SHALL have parameter CACHE_SIZE, default 1024, data capacity in bytes (power of two, >= 8*LINE_WORDS).
REQ-002 SHALL have parameter LINE_WORDS, default 4, 32-bit words per line (power of two, 1..16).
REQ-003 SHALL have ports, in order:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- read_request  in  1  processor load request.
- write_request  in  1  processor store request.
- addr  in  32  byte address; bits [1:0] ignored.
- write_data  in  32  store data.
- write_strb  in  4  store byte enables; bit n enables byte lane n.
- invalidate  in  1  single-cycle pulse; invalidate whole cache.
- response  out  1  one-cycle completion pulse for the current request.
- read_data  out  32  load data; valid while response=1.
- memory_read_request  out  1  word read to memory.
- memory_write_request  out  1  word write to memory.
- memory_response  in  1  one-cycle memory completion pulse.
- memory_addr  out  32  word-aligned memory address.
- memory_write_data  out  32  store data to memory.
- memory_write_strb  out  4  byte enables to memory.
- memory_read_data  in  32  memory read data; valid with memory_response.

Function
REQ-004 SHALL be direct-mapped: SETS=CACHE_SIZE/(4*LINE_WORDS); offset=addr[log2(LINE_WORDS)+1:2], index=next log2(SETS) bits, tag=remaining upper bits; one valid bit and one tag per line.
REQ-005 Processor SHALL hold request, addr, write_data, write_strb stable until response; read_request and write_request both high SHALL be treated as a write.
REQ-006 FSM states: IDLE, REFILL, WRITE, RESPOND.
REQ-007 Read hit in IDLE: response=1 combinationally in the same cycle, read_data=cached word, no memory request, state stays IDLE.
REQ-008 Read miss in IDLE: go REFILL; issue LINE_WORDS sequential word reads from line base (offset 0 upward); each memory_response stores memory_read_data into the line and advances the word counter.
REQ-009 After the last refill word: set valid, write tag, go RESPOND; RESPOND drives response=1 with read_data from the now-filled line for one cycle, then IDLE.
REQ-010 Write in IDLE (write-through): on hit merge write_data into the cached word per write_strb in the same cycle; on miss the cache is unchanged (no allocate); go WRITE.
REQ-011 WRITE: memory_write_request=1 with memory_addr={addr[31:2],2'b00}, memory_write_data=write_data, memory_write_strb=write_strb until memory_response; then RESPOND, then IDLE.
REQ-012 Memory requests SHALL be level signals held until memory_response; at most one outstanding; never both read and write high.
REQ-013 invalidate in IDLE SHALL clear all valid bits at the next edge, with response=0 that cycle; invalidate during REFILL/WRITE/RESPOND SHALL be latched and applied on entry to IDLE, after that request completes; refill data written during a pending invalidate SHALL also be invalidated.
REQ-014 memory_response in IDLE or RESPOND SHALL be ignored.
REQ-015 New requests SHALL be accepted only in IDLE.

Reset
REQ-016 rst_n=0 SHALL force IDLE, clear all valid bits, word counter and pending invalidate; response, memory_read_request, memory_write_request=0 from the next cycle, including mid-REFILL/WRITE. Tag/data arrays are not reset.

Configuration
REQ-017 Macro DCACHE_WRITE_ALLOCATE_EN: when defined, a write miss first performs a full REFILL of the line, then merges write_data per write_strb, then enters WRITE; when undefined, REQ-010 no-allocate applies.

Verification
REQ-018 Defaults, cold cache, read 0x100 -> reads 0x100,0x104,0x108,0x10C in order; response one cycle after 4th memory_response, read_data = word returned for 0x100.
REQ-019 Then read 0x108 -> response same cycle, read_data = refill word 2, no memory request.
REQ-020 Write 0xAABBCCDD, strb 0011, to 0x104 (hit) -> memory write 0x104 strb 0011; later read 0x104 hits with upper half unchanged, lower half 0xCCDD.
REQ-021 Read 0x500 (same index as 0x100) -> refill miss 0x500..0x50C; subsequent read 0x100 misses again.
REQ-022 invalidate pulse in IDLE then read 0x500 -> miss; invalidate during REFILL -> request completes, next read of same line misses.
REQ-023 rst_n=0 after 2nd refill word -> memory_read_request=0 next cycle, IDLE, later read 0x100 misses; with DCACHE_WRITE_ALLOCATE_EN, write miss 0x200 -> 4 reads then 1 write, then read 0x200 hits.
